uart_in_feeder: RTL and testbench

Simulation-side responder for the SoC's UART input port, on the opposite side of the link from the console printer. The host side (DPI glue or a bench) pushes characters into a small FIFO. The DUT polls the port with `io_uart_in_valid` and gets the head character, or `8'hff` ("no data") when nothing is available. An optional inter-character gap models line pacing, so software polling loops see realistic empty reads.

---
 rtl/uart_in_feeder_pkg.sv | 14 +
 rtl/sim_sync_fifo.sv | 64 ++++++
 rtl/uart_in_feeder.sv | 85 ++++++++
 tb/tb_uart_in_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_in_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_in_feeder_pkg                                     |
// | Description : Shared UART sim types and the "no data" character.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package uart_in_feeder_pkg;

    typedef logic [7:0] uart_ch_t;

    localparam uart_ch_t UART_EMPTY_CH = 8'hff;

endpackage
`default_nettype wire

// File: rtl/sim_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sim_sync_fifo                                          |
// | Description : Circular-buffer FIFO with occupancy count, no bypass.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sim_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push && (r_count != c_CW'(DEPTH));
    assign w_pop_ok  = pop  && (r_count != '0);

    // Storage is deliberately left unreset; only pointers define content.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_in_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_in_feeder                                         |
// | Description : Host-fed UART input responder with pacing gap.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_in_feeder
    import uart_in_feeder_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 0,
    parameter uart_ch_t    EMPTY_CH   = UART_EMPTY_CH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   host_valid,
    input  uart_ch_t               host_ch,
    output logic                   host_ready,
    input  logic                   io_uart_in_valid,
    output uart_ch_t               io_uart_in_ch,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            rx_total,
    output logic [31:0]            empty_reads
);

    localparam int c_CW = $clog2(DEPTH) + 1;

    uart_ch_t          w_head;
    logic [c_CW-1:0]   w_count;
    logic              w_deliverable;
    logic              w_pop;
    logic              w_push;
    logic [31:0]       r_gap_cnt;
    logic [31:0]       r_rx_total;
    logic [31:0]       r_empty_reads;

    assign host_ready    = (w_count != c_CW'(DEPTH));
    assign w_push        = host_valid && host_ready;
    assign w_deliverable = (w_count != '0) && (r_gap_cnt == '0);
    assign w_pop         = io_uart_in_valid && w_deliverable;
    assign io_uart_in_ch = w_deliverable ? w_head : EMPTY_CH;

    sim_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (host_ch),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_count)
    );

    // Gap counter: READY when zero, GAP otherwise; a delivery reloads it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (w_pop) begin
            r_gap_cnt <= 32'(GAP_CYCLES);
        end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_total    <= '0;
            r_empty_reads <= '0;
        end else if (io_uart_in_valid) begin
            if (w_deliverable) begin
                r_rx_total <= r_rx_total + 32'd1;
            end else begin
                r_empty_reads <= r_empty_reads + 32'd1;
            end
        end
    end

    assign fifo_count  = w_count;
    assign rx_total    = r_rx_total;
    assign empty_reads = r_empty_reads;

endmodule
`default_nettype wire

// File: tb/tb_uart_in_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_in_feeder                                      |
// | Description : Bench for two feeders (gap 0 and gap 3) vs a model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_in_feeder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        host_valid = 1'b0;
    logic [7:0]  host_ch = 8'h00;
    logic        io_uart_in_valid = 1'b0;

    logic        ready0, ready1;
    logic [7:0]  ch0, ch1;
    logic [4:0]  cnt0, cnt1;
    logic [31:0] rx0, rx1, er0, er1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    uart_in_feeder #(.DEPTH(16), .GAP_CYCLES(0), .EMPTY_CH(8'hff)) u_dut0 (
        .clock(clock), .reset(reset), .host_valid(host_valid), .host_ch(host_ch),
        .host_ready(ready0), .io_uart_in_valid(io_uart_in_valid), .io_uart_in_ch(ch0),
        .fifo_count(cnt0), .rx_total(rx0), .empty_reads(er0)
    );

    uart_in_feeder #(.DEPTH(16), .GAP_CYCLES(3), .EMPTY_CH(8'hff)) u_dut1 (
        .clock(clock), .reset(reset), .host_valid(host_valid), .host_ch(host_ch),
        .host_ready(ready1), .io_uart_in_valid(io_uart_in_valid), .io_uart_in_ch(ch1),
        .fifo_count(cnt1), .rx_total(rx1), .empty_reads(er1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue per instance plus "cycle of last delivery".
    logic [7:0] mq [2][4096];
    int mh [2];
    int mt [2];
    int last_deliv [2];
    int m_rx [2];
    int m_er [2];
    int cyc = 0;
    bit started = 1'b0;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int m_size(input int k);
        return mt[k] - mh[k];
    endfunction

    function automatic bit m_deliv(input int k);
        return (m_size(k) != 0) && (cyc - last_deliv[k] >= gap_of(k) + 1);
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mh[k] = 0; mt[k] = 0; m_rx[k] = 0; m_er[k] = 0;
                last_deliv[k] = -1000;
            end else begin
                bit ready_now;
                bit deliv_now;
                ready_now = (m_size(k) != 16);
                deliv_now = m_deliv(k);
                if (io_uart_in_valid) begin
                    if (deliv_now) begin
                        mh[k]++; m_rx[k]++; last_deliv[k] = cyc;
                    end else begin
                        m_er[k]++;
                    end
                end
                if (host_valid && ready_now) begin
                    mq[k][mt[k] % 4096] = host_ch;
                    mt[k]++;
                end
            end
        end
        if (reset) started = 1'b1;
        cyc++;
    end

    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [7:0] exp_ch;
                exp_ch = m_deliv(k) ? mq[k][mh[k] % 4096] : 8'hff;
                check($sformatf("ch%0d", k), (k == 0) ? {24'd0, ch0} : {24'd0, ch1}, {24'd0, exp_ch});
                check($sformatf("ready%0d", k), (k == 0) ? {31'd0, ready0} : {31'd0, ready1},
                      {31'd0, (m_size(k) != 16)});
                check($sformatf("count%0d", k), (k == 0) ? {27'd0, cnt0} : {27'd0, cnt1}, 32'(m_size(k)));
                check($sformatf("rx%0d", k), (k == 0) ? rx0 : rx1, 32'(m_rx[k]));
                check($sformatf("empty%0d", k), (k == 0) ? er0 : er1, 32'(m_er[k]));
            end
        end
    end

    task automatic set_in(input bit hv, input logic [7:0] hc, input bit rv);
        host_valid = hv;
        host_ch = hc;
        io_uart_in_valid = rv;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int e0, r0;
        reset = 1'b1;
        set_in(0, 8'h00, 0);
        tick(); tick();
        check("reset_ch0", {24'd0, ch0}, 32'h0000_00ff);
        check("reset_ready0", {31'd0, ready0}, 32'd1);
        check("reset_cnt0", {27'd0, cnt0}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            set_in(0, 8'h00, 1);
            check("idle_ch0", {24'd0, ch0}, 32'h0000_00ff);
            tick();
        end
        check("idle_empty0", er0, 32'd4);
        check("idle_rx0", rx0, 32'd0);

        for (int i = 0; i < 3; i++) begin
            set_in(1, 8'h41 + 8'(i), 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 8'h00, 1);
            check("abc_ch0", {24'd0, ch0}, 32'h41 + 32'(i));
            tick();
        end
        check("abc_rx0", rx0, 32'd3);
        check("abc_cnt0", {27'd0, cnt0}, 32'd0);
        set_in(0, 8'h00, 1);
        repeat (12) tick();
        set_in(0, 8'h00, 0);
        repeat (4) tick();

        for (int i = 0; i < 16; i++) begin
            set_in(1, 8'h60 + 8'(i), 0);
            tick();
        end
        check("full_ready0", {31'd0, ready0}, 32'd0);
        check("full_cnt0", {27'd0, cnt0}, 32'd16);
        set_in(1, 8'h70, 1);
        check("full_head0", {24'd0, ch0}, 32'h60);
        tick();
        check("popfull_cnt0", {27'd0, cnt0}, 32'd15);
        check("popfull_ready0", {31'd0, ready0}, 32'd1);
        set_in(1, 8'h70, 0);
        tick();
        check("refill_cnt0", {27'd0, cnt0}, 32'd16);
        set_in(0, 8'h00, 1);
        repeat (80) tick();
        set_in(0, 8'h00, 0);
        repeat (5) tick();

        set_in(1, 8'h31, 0); tick();
        set_in(1, 8'h32, 0); tick();
        e0 = int'(er1);
        r0 = int'(rx1);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 8'h00, 1);
            check("gap_ch1", {24'd0, ch1}, (i == 0) ? 32'h31 : (i == 4) ? 32'h32 : 32'hff);
            tick();
        end
        check("gap_empty1", er1 - 32'(e0), 32'd3);
        check("gap_rx1", rx1 - 32'(r0), 32'd2);
        set_in(0, 8'h00, 0);
        repeat (5) tick();

        set_in(1, 8'h5a, 1);
        check("nobypass_ch0", {24'd0, ch0}, 32'hff);
        tick();
        set_in(0, 8'h00, 1);
        check("nobypass_next_ch0", {24'd0, ch0}, 32'h5a);
        tick();
        set_in(0, 8'h00, 0);
        repeat (5) tick();

        for (int i = 0; i < 5; i++) begin
            set_in(1, 8'h20 + 8'(i), 0);
            tick();
        end
        reset = 1'b1;
        set_in(0, 8'h00, 0);
        tick();
        reset = 1'b0;
        check("rst_cnt0", {27'd0, cnt0}, 32'd0);
        check("rst_rx0", rx0, 32'd0);
        check("rst_ch0", {24'd0, ch0}, 32'hff);
        set_in(0, 8'h00, 1);
        tick();
        check("rst_empty0", er0, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            set_in($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1);
            tick();
        end
        reset = 1'b0;
        set_in(0, 8'h00, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
